imem_uart_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 90 +++++++++
 rtl/imem_uart_loader.sv | 157 +++++++++++++++
 tb/tb_imem_uart_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Holds the framing FSM state encoding, header byte and baud divisor helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE,
    LDR_WAIT_HDR,
    LDR_GET_LEN,
    LDR_GET_DATA,
    LDR_GET_CSUM,
    LDR_DONE,
    LDR_ERROR
  } ldr_state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver on an already-synchronised rx line.
// Reports a good byte with byte_valid, or a missing stop bit with byte_err.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] data
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          rx_prev;
  logic          armed;
  logic          sample;

  assign sample = (state == RX_DATA) && (cnt == FULL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      rx_prev    <= 1'b1;
      armed      <= 1'b0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_prev    <= rx;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        // Idle doubles as the start-bit qualifier: a low level must survive to half a bit.
        RX_IDLE: begin
          if (!armed) begin
            if (rx_prev && !rx) begin
              armed <= 1'b1;
              cnt   <= '0;
            end
          end else if (cnt == HALF_LAST) begin
            armed <= 1'b0;
            cnt   <= '0;
            if (!rx) begin
              state   <= RX_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL_LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL_LAST) begin
            cnt        <= '0;
            state      <= RX_IDLE;
            byte_valid <= rx;
            byte_err   <= !rx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Shift register fills LSB first; only meaningful when byte_valid pulses.
  always_ff @(posedge clk) begin
    if (sample) data <= {rx, data[7:1]};
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Loads a framed program image from UART into instruction memory, 32 bits per write,
// holding the core in reset until a load completes with a matching checksum.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);

  logic rx_s1, rx_s2, st_s1, st_s2, st_d;
  logic trig;
  logic bv, be;
  logic [7:0] rx_data;

  ldr_state_t      state;
  logic [ADDR_W:0] n_words;
  logic [7:0]      csum;
  logic [1:0]      byte_idx;
  logic [23:0]     word_asm;
  logic            in_frame;
  logic            frame_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      st_s1 <= 1'b0;
      st_s2 <= 1'b0;
      st_d  <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      st_s1 <= start;
      st_s2 <= st_s1;
      st_d  <= st_s2;
    end
  end

  assign trig = st_s2 & ~st_d;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_s2),
    .byte_valid(bv),
    .byte_err  (be),
    .data      (rx_data)
  );

  always_comb begin
    in_frame   = (state == LDR_WAIT_HDR) || (state == LDR_GET_LEN) ||
                 (state == LDR_GET_DATA) || (state == LDR_GET_CSUM);
    frame_fail = in_frame && (be || ((state == LDR_GET_CSUM) && bv && (rx_data != csum)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LDR_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
      n_words    <= '0;
      csum       <= '0;
      byte_idx   <= '0;
    end else begin
      imem_we <= 1'b0;
      // Address advances only after the strobe cycle so the write sees the old address.
      if (imem_we) imem_addr <= imem_addr + 1'b1;
      case (state)
        LDR_IDLE: cpu_rst_n <= 1'b1;
        LDR_WAIT_HDR: begin
          if (bv && (rx_data == HDR_BYTE)) state <= LDR_GET_LEN;
        end
        LDR_GET_LEN: begin
          if (bv) begin
            n_words <= (rx_data[ADDR_W-1:0] == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                   : {1'b0, rx_data[ADDR_W-1:0]};
            state   <= LDR_GET_DATA;
          end
        end
        LDR_GET_DATA: begin
          if (bv) begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              imem_wdata <= {rx_data, word_asm};
              imem_we    <= 1'b1;
              word_count <= word_count + 1'b1;
              if ((word_count + 1'b1) == n_words) state <= LDR_GET_CSUM;
            end
          end
        end
        LDR_GET_CSUM: begin
          if (bv && (rx_data == csum)) begin
            state     <= LDR_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            cpu_rst_n <= 1'b1;
          end
        end
        default: ;
      endcase
      if (frame_fail) begin
        state     <= LDR_ERROR;
        busy      <= 1'b0;
        done      <= 1'b0;
        frame_err <= 1'b1;
        cpu_rst_n <= 1'b0;
      end
      if (trig && !in_frame) begin
        state      <= LDR_WAIT_HDR;
        busy       <= 1'b1;
        done       <= 1'b0;
        frame_err  <= 1'b0;
        cpu_rst_n  <= 1'b0;
        word_count <= '0;
        imem_addr  <= '0;
        csum       <= '0;
        byte_idx   <= '0;
      end
    end
  end

  // Lower three bytes of the word under assembly; the top byte goes straight to imem_wdata.
  always_ff @(posedge clk) begin
    if ((state == LDR_GET_DATA) && bv) begin
      case (byte_idx)
        2'd0:    word_asm[7:0]   <= rx_data;
        2'd1:    word_asm[15:8]  <= rx_data;
        2'd2:    word_asm[23:16] <= rx_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: table of frames checked against a frame-level model,
// plus hand sequences for the rx glitch, stop-bit error and mid-load reset.
module tb_imem_uart_loader;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int ADDR_W = 4;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              uart_rx = 1'b1;
  logic              start = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              frame_err;
  logic [ADDR_W:0]   word_count;

  imem_uart_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .start     (start),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];
  int                bv_count = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wdata);
    end
    if (dut.u_rx.byte_valid) bv_count++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_val;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_timeout"}, (t < 2000), 1'b1);
  endtask

  typedef struct {
    int         len_byte;
    int         n_words;
    bit         fixed_words;
    logic [7:0] csum_flip;
    bit         junk;
    bit         exp_done;
  } vec_t;

  vec_t        vecs[7];
  logic [7:0]  fr[$];
  logic [31:0] wq[$];
  logic [31:0] w;
  logic [7:0]  cs;
  int          base;
  int          bv_base;

  initial begin
    vecs[0] = '{2, 2, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{2, 2, 1'b1, 8'hD5, 1'b0, 1'b0};
    vecs[2] = '{3, 3, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{2, 2, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{5, 5, 1'b0, 8'h40, 1'b0, 1'b0};
    vecs[5] = '{0, 16, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{1, 1, 1'b0, 8'h00, 1'b0, 1'b1};

    repeat (5) @(negedge clk);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_word_count", word_count, 0);
    rst_n = 1'b1;
    #1 check("cpu_rst_n_before_edge", cpu_rst_n, 0);
    @(negedge clk);
    check("cpu_rst_n_after_edge", cpu_rst_n, 1);

    for (int v = 0; v < 7; v++) begin
      fr.delete();
      wq.delete();
      cs = 8'h00;
      for (int i = 0; i < vecs[v].n_words; i++) begin
        if (vecs[v].fixed_words) w = (i == 0) ? 32'h00000513 : 32'h00500093;
        else w = $urandom;
        wq.push_back(w);
      end
      if (vecs[v].junk) begin
        fr.push_back(8'h11);
        fr.push_back(8'h22);
      end
      fr.push_back(8'hA5);
      fr.push_back(vecs[v].len_byte[7:0]);
      foreach (wq[i]) begin
        w = wq[i];
        for (int k = 0; k < 4; k++) begin
          fr.push_back(w[8*k +: 8]);
          cs = cs ^ w[8*k +: 8];
        end
      end
      fr.push_back(cs ^ vecs[v].csum_flip);

      base = cap_addr.size();
      pulse_start();
      check($sformatf("v%0d_busy_on_start", v), busy, 1);
      check($sformatf("v%0d_cpu_held", v), cpu_rst_n, 0);
      foreach (fr[i]) send_byte(fr[i], 1'b1);
      wait_idle($sformatf("v%0d", v));

      check($sformatf("v%0d_nwrites", v), cap_addr.size() - base, vecs[v].n_words);
      for (int i = 0; i < vecs[v].n_words && base + i < cap_addr.size(); i++) begin
        check($sformatf("v%0d_addr%0d", v, i), cap_addr[base+i], i % DEPTH);
        check($sformatf("v%0d_data%0d", v, i), cap_data[base+i], wq[i]);
      end
      check($sformatf("v%0d_done", v), done, vecs[v].exp_done);
      check($sformatf("v%0d_frame_err", v), frame_err, !vecs[v].exp_done);
      check($sformatf("v%0d_cpu_rst_n", v), cpu_rst_n, vecs[v].exp_done);
      check($sformatf("v%0d_word_count", v), word_count, vecs[v].n_words);
      check($sformatf("v%0d_imem_addr", v), imem_addr, vecs[v].n_words % DEPTH);
    end

    // Short low glitch while waiting for the header must not produce a byte.
    pulse_start();
    base    = cap_addr.size();
    bv_base = bv_count;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    check("glitch_no_byte", bv_count - bv_base, 0);
    check("glitch_busy", busy, 1);
    check("glitch_cpu_held", cpu_rst_n, 0);
    w = $urandom;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    send_byte(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24], 1'b1);
    wait_idle("glitch_frame");
    check("glitch_frame_done", done, 1);
    check("glitch_frame_nwrites", cap_addr.size() - base, 1);
    if (cap_data.size() > base) check("glitch_frame_data", cap_data[base], w);

    // Missing stop bit in the middle of the second word.
    pulse_start();
    base = cap_addr.size();
    w = $urandom;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h77, 1'b0);
    repeat (10) @(negedge clk);
    check("stoperr_frame_err", frame_err, 1);
    check("stoperr_busy", busy, 0);
    check("stoperr_done", done, 0);
    check("stoperr_cpu_held", cpu_rst_n, 0);
    check("stoperr_nwrites", cap_addr.size() - base, 1);
    if (cap_data.size() > base) check("stoperr_data0", cap_data[base], w);

    // Reset asserted partway through a frame.
    pulse_start();
    w = $urandom | 32'h1;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'h81, 1'b1);
    check("midrst_pre_word_count", word_count, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we", imem_we, 0);
    check("midrst_addr", imem_addr, 0);
    check("midrst_wdata", imem_wdata, 0);
    check("midrst_cpu_rst_n", cpu_rst_n, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_word_count", word_count, 0);
    base = cap_addr.size();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release_cpu_rst_n", cpu_rst_n, 1);
    check("midrst_release_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("midrst_no_write", cap_addr.size() - base, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
